// File: rtl/decode_issue_queue_if.sv
// decode_issue_queue_if: handshake bundle between decode, the issue queue and execute.
//   slave  : the queue side (takes in_*, hazard, flush, out_ready; drives the rest)
//   master : the decode/execute side (mirror of slave)
// Parameters must match the decode_issue_queue instance they are connected to.
interface decode_issue_queue_if #(
  parameter int PAYLOAD_W = 192,
  parameter int DEPTH     = 2,
  parameter int CNT_W     = 16
);
  logic                     in_valid;
  logic                     in_ready;
  logic [PAYLOAD_W-1:0]     in_payload;
  logic [31:0]              in_instr;
  logic                     hazard;
  logic                     flush;
  logic                     out_valid;
  logic                     out_ready;
  logic [PAYLOAD_W-1:0]     out_payload;
  logic [31:0]              out_instr;
  logic [$clog2(DEPTH):0]   occupancy;
  logic [CNT_W-1:0]         bubble_cnt;

  modport master (
    output in_valid, in_payload, in_instr, hazard, flush, out_ready,
    input  in_ready, out_valid, out_payload, out_instr, occupancy, bubble_cnt
  );

  modport slave (
    input  in_valid, in_payload, in_instr, hazard, flush, out_ready,
    output in_ready, out_valid, out_payload, out_instr, occupancy, bubble_cnt
  );
endinterface

// File: rtl/decode_issue_queue.sv
// decode_issue_queue: DEPTH-entry FIFO of decoded instructions between decode and
// execute. Valid/ready on both sides; hazard blocks intake, flush empties the queue
// in one cycle, and an empty queue presents payload 0 / NOP_INSTR. bubble_cnt
// saturates while counting cycles where execute is ready but gets a NOP.
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   q     : decode_issue_queue_if.slave (in_*, hazard, flush, out_*, occupancy, bubble_cnt)
module decode_issue_queue #(
  parameter int          PAYLOAD_W = 192,
  parameter int          DEPTH     = 2,
  parameter logic [31:0] NOP_INSTR = 32'h00000013,
  parameter int          CNT_W     = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  decode_issue_queue_if.slave     q
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [PAYLOAD_W-1:0] payload;
    logic [31:0]          instr;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [CNT_W-1:0] bubble_cnt;
  logic          full, out_valid, in_ready, push, pop;

  assign full      = (count == CW'(DEPTH));
  assign out_valid = (count != '0);
  // Intake readiness is independent of out_ready: no combinational path through the queue.
  assign in_ready  = rst_n & ~q.flush & ~q.hazard & ~full;
  assign push      = q.in_valid & in_ready;
  assign pop       = out_valid & q.out_ready;

  assign q.in_ready    = in_ready;
  assign q.out_valid   = out_valid;
  // Empty queue shows a canonical bubble, never stale storage.
  assign q.out_payload = out_valid ? mem[rd_ptr].payload : '0;
  assign q.out_instr   = out_valid ? mem[rd_ptr].instr   : NOP_INSTR;
  assign q.occupancy   = count;
  assign q.bubble_cnt  = bubble_cnt;

  // Storage is not reset; push is already gated off by reset and flush via in_ready.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{payload: q.in_payload, instr: q.in_instr};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (q.flush) begin
      // Flush wins over a same-cycle pop.
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Bubble counter survives flush; only reset clears it.
  always_ff @(posedge clk) begin
    if (!rst_n)
      bubble_cnt <= '0;
    else if (~out_valid & q.out_ready & ~&bubble_cnt)
      bubble_cnt <= bubble_cnt + 1'b1;
  end
endmodule

// File: tb/tb_decode_issue_queue.sv
// Two queue instances (DEPTH=2/CNT_W=4 and DEPTH=4/CNT_W=16) share one stimulus
// stream; each is compared every cycle against a log-based FIFO model.
module tb_decode_issue_queue;
  localparam int PW = 192;
  localparam logic [31:0] NOP = 32'h00000013;

  logic clk, rst_n;
  logic in_valid, hazard, flush, out_ready;
  logic [PW-1:0] in_payload;
  logic [31:0]   in_instr;

  decode_issue_queue_if #(.PAYLOAD_W(PW), .DEPTH(2), .CNT_W(4))  if0 ();
  decode_issue_queue_if #(.PAYLOAD_W(PW), .DEPTH(4), .CNT_W(16)) if1 ();

  assign if0.in_valid = in_valid;   assign if1.in_valid = in_valid;
  assign if0.hazard = hazard;       assign if1.hazard = hazard;
  assign if0.flush = flush;         assign if1.flush = flush;
  assign if0.out_ready = out_ready; assign if1.out_ready = out_ready;
  assign if0.in_payload = in_payload; assign if1.in_payload = in_payload;
  assign if0.in_instr = in_instr;   assign if1.in_instr = in_instr;

  decode_issue_queue #(.PAYLOAD_W(PW), .DEPTH(2), .CNT_W(4)) u_dq0 (
    .clk(clk), .rst_n(rst_n), .q(if0.slave));
  decode_issue_queue #(.PAYLOAD_W(PW), .DEPTH(4), .CNT_W(16)) u_dq1 (
    .clk(clk), .rst_n(rst_n), .q(if1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed outputs gathered per instance.
  logic          got_ir [2];
  logic          got_ov [2];
  logic [PW-1:0] got_pl [2];
  logic [31:0]   got_in [2];
  int            got_occ [2];
  int            got_bub [2];
  always_comb begin
    got_ir[0] = if0.in_ready;  got_ir[1] = if1.in_ready;
    got_ov[0] = if0.out_valid; got_ov[1] = if1.out_valid;
    got_pl[0] = if0.out_payload; got_pl[1] = if1.out_payload;
    got_in[0] = if0.out_instr; got_in[1] = if1.out_instr;
    got_occ[0] = 32'(if0.occupancy); got_occ[1] = 32'(if1.occupancy);
    got_bub[0] = 32'(if0.bubble_cnt); got_bub[1] = 32'(if1.bubble_cnt);
  end

  // Model: every accepted instruction is appended to a log; the queue is the
  // window [hd, tl). Nothing wraps, so ordering follows from the indices.
  localparam int LOGN = 4096;
  logic [PW-1:0] lg_pl [2][LOGN];
  logic [31:0]   lg_in [2][LOGN];
  int hd [2], tl [2], bub [2];
  int dep  [2] = '{2, 4};
  int bmax [2] = '{15, 65535};

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] rnd_pl();
    logic [PW-1:0] v;
    for (int i = 0; i < PW/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // One clock cycle: drive, check at negedge, advance model, step past posedge.
  task automatic cycle(input bit iv, input bit hz, input bit fl, input bit ordy, input bit rs);
    int  cnt;
    bit  e_ir, do_pop;
    rst_n = rs; in_valid = iv; hazard = hz; flush = fl; out_ready = ordy;
    in_payload = rnd_pl(); in_instr = $urandom;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      cnt  = tl[k] - hd[k];
      e_ir = rs && !fl && !hz && (cnt < dep[k]);
      chk($sformatf("in_ready%0d", k), 256'(got_ir[k]), 256'(e_ir));
      chk($sformatf("out_valid%0d", k), 256'(got_ov[k]), 256'(cnt != 0));
      chk($sformatf("out_instr%0d", k), 256'(got_in[k]),
          256'((cnt != 0) ? lg_in[k][hd[k]] : NOP));
      chk($sformatf("out_payload%0d", k), 256'(got_pl[k]),
          256'((cnt != 0) ? lg_pl[k][hd[k]] : '0));
      chk($sformatf("occupancy%0d", k), 256'(got_occ[k]), 256'(cnt));
      chk($sformatf("bubble_cnt%0d", k), 256'(got_bub[k]), 256'(bub[k]));
      if (!rs) begin
        hd[k] = tl[k];
        bub[k] = 0;
      end else begin
        if (cnt == 0 && ordy && bub[k] < bmax[k]) bub[k]++;
        do_pop = (cnt != 0) && ordy;
        if (fl) hd[k] = tl[k];
        else begin
          if (do_pop) hd[k]++;
          if (iv && e_ir) begin
            lg_pl[k][tl[k]] = in_payload;
            lg_in[k][tl[k]] = in_instr;
            tl[k]++;
          end
        end
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin hd[k] = 0; tl[k] = 0; bub[k] = 0; end
    rst_n = 1'b0; in_valid = 1'b0; hazard = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_payload = '0; in_instr = '0;
    repeat (2) @(posedge clk);
    #1;
    cycle(0, 0, 0, 1, 0);                  // still in reset: in_ready low, no bubbles
    // Idle with execute ready: ten bubbles.
    repeat (10) cycle(0, 0, 0, 1, 1);
    chk("idle_bub10", 256'(got_bub[0]), 256'd10);
    chk("idle_instr", 256'(got_in[1]), 256'(NOP));
    // Fill DEPTH=2 then drain.
    cycle(1, 0, 0, 0, 1);
    cycle(1, 0, 0, 0, 1);
    chk("full_occ", 256'(got_occ[0]), 256'd2);
    chk("full_ready", 256'(got_ir[0]), 256'd0);
    cycle(1, 0, 0, 1, 1);
    repeat (4) cycle(0, 0, 0, 1, 1);
    // Back-to-back stream, pointers wrap.
    repeat (8) cycle(1, 0, 0, 1, 1);
    cycle(0, 0, 0, 1, 1);
    // Hazard while one entry is held.
    cycle(1, 0, 0, 0, 1);
    repeat (3) cycle(1, 1, 0, 1, 1);
    cycle(0, 0, 0, 1, 1);
    // Full queue, flush with pop and push requested.
    repeat (4) cycle(1, 0, 0, 0, 1);
    cycle(1, 0, 1, 1, 1);
    chk("flush_occ0", 256'(got_occ[0]), 256'd0);
    chk("flush_occ1", 256'(got_occ[1]), 256'd0);
    chk("flush_nop", 256'(got_in[0]), 256'(NOP));
    cycle(0, 0, 0, 0, 1);
    // Saturate the 4-bit counter, then reset it.
    repeat (20) cycle(0, 0, 0, 1, 1);
    chk("bub_sat", 256'(got_bub[0]), 256'd15);
    cycle(0, 0, 0, 1, 0);
    chk("bub_rst", 256'(got_bub[0]), 256'd0);
    // Randomized traffic with occasional hazard, flush and reset.
    for (int i = 0; i < 1500; i++)
      cycle($urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0,
            $urandom_range(0, 39) == 0, $urandom_range(0, 9) < 6,
            $urandom_range(0, 99) != 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/decode_issue_queue.md
# decode_issue_queue

Parametrised successor to the single-entry ID/EX pipeline register. It buffers up to DEPTH decoded instructions, each carrying its control/operand payload and raw instruction word, between decode and execute. Upstream and downstream use valid/ready handshakes. Hazard stalls intake, flush empties the whole queue in one cycle, and an empty queue presents a canonical NOP so execute always sees a legal bubble. A saturating bubble counter supports performance debug.

## Interface
Parameters:
- PAYLOAD_W, 192: width of the decoded payload (operands, immediate, PC, control bits).
- DEPTH, 2: number of queue entries; a power of two, at least 2.
- NOP_INSTR, 32'h00000013: instruction word presented when the queue is empty.
- CNT_W, 16: width of the bubble counter.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- rst_n, input, 1: reset, synchronous, active-low.
- in_valid, input, 1: decode presents an instruction.
- in_ready, output, 1: queue accepts this cycle.
- in_payload, input, PAYLOAD_W: decoded payload.
- in_instr, input, 32: raw instruction word.
- hazard, input, 1: load-use or other decode hazard; blocks intake.
- flush, input, 1: branch/exception flush; discards all entries.
- out_valid, output, 1: head entry is valid.
- out_ready, input, 1: execute consumes the head.
- out_payload, output, PAYLOAD_W: head payload; all zeros when empty.
- out_instr, output, 32: head instruction word; NOP_INSTR when empty.
- occupancy, output, $clog2(DEPTH)+1: number of valid entries.
- bubble_cnt, output, CNT_W: saturating count of bubble cycles.

## Operation
- Storage is a circular buffer of DEPTH entries, each {payload, instr}, addressed by wr_ptr and rd_ptr ($clog2(DEPTH) bits each, wrapping naturally), with count of $clog2(DEPTH)+1 bits.
- in_ready = rst_n & ~flush & ~hazard & (count != DEPTH). It does not depend on out_ready, so there is no combinational ready path.
- push = in_valid & in_ready: writes mem[wr_ptr] and increments wr_ptr.
- pop = out_valid & out_ready: increments rd_ptr.
- count update:
  - +1 on push only.
  - −1 on pop only.
  - unchanged when push and pop happen together, or when neither happens.
- out_valid = (count != 0).
- out_payload / out_instr are read from mem[rd_ptr] when out_valid is high. When the queue is empty they are forced to 0 and NOP_INSTR, regardless of stale storage contents.
- occupancy = count.
- flush:
  - wr_ptr, rd_ptr and count go to 0 on the next edge.
  - A pop in the same cycle is ignored; flush wins.
  - in_ready is low, so nothing is pushed.
- hazard: blocks push only. Pops continue, so the queue drains normally.
- bubble_cnt increments by 1 on each cycle where out_valid=0 and out_ready=1, i.e. execute receives a NOP. It saturates at all-ones and is not cleared by flush.
- Reset overrides every other input, including flush and hazard.

## Timing
- Reset values:
  - in_ready=0 while rst_n=0, and 1 in the first cycle after release if hazard and flush are low.
  - out_valid=0, out_payload=0, out_instr=NOP_INSTR, occupancy=0, bubble_cnt=0.
  - Storage contents are not reset.
- Latency: an entry pushed at edge N is visible at the output after edge N, i.e. in cycle N+1. There is no same-cycle bypass from in_* to out_*.
- Throughput: one push and one pop per cycle. Sustained rate is one instruction per cycle with DEPTH≥2 and out_ready held high.
- Full (count=DEPTH): in_ready=0. A pop in that cycle frees a slot for the next cycle, not the current one.
- Empty: out_valid=0 and the output carries the NOP fields; out_ready is ignored for pointer updates.
- Pointer wrap from DEPTH−1 to 0 is seamless; ordering is strictly FIFO.
- Reset asserted mid-operation: the queue is empty after that edge, and any push or pop in that cycle is discarded.

## Test plan
- Reset then idle, out_ready=1 for 10 cycles -> out_valid=0, out_instr=32'h00000013, out_payload=0, bubble_cnt=10.
- DEPTH=2: push A, B with out_ready=0 -> occupancy=2, in_ready=0. Then out_ready=1 -> out_instr=A, then B, then NOP. in_ready returns in the cycle after the first pop.
- Continuous stream of 8 instructions with out_ready=1 and DEPTH=4 -> outputs appear in order with 1-cycle latency, occupancy stays ≤1, and the pointers wrap twice with no loss.
- hazard=1 for 3 cycles while in_valid=1 and the queue holds 1 entry -> in_ready=0 throughout, the held entry pops, then 2 bubble cycles are counted and occupancy=0 until hazard falls.
- Queue full (2 entries), flush=1 together with out_ready=1 and in_valid=1 -> next cycle occupancy=0, out_instr=NOP, no entry consumed or accepted.
- Preload bubble_cnt near 2^CNT_W−1 using CNT_W=4 and 20 idle cycles -> bubble_cnt holds at 15, and rst_n=0 then returns it to 0.
